// File: rtl/spi_ctrl_master.sv
// spi_ctrl_master: SPI mode-0 master that shifts out one 16-bit {rw, addr, data} frame per start
// and captures cipo during the data byte.
module spi_ctrl_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       cipo,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ncs,
    output logic       sclk,
    output logic       copi
);
    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;
    state_t      state, state_n;
    logic [7:0]  cnt, lim;
    logic [3:0]  bidx;
    logic [15:0] sr;
    logic [7:0]  cap;
    logic        phase_end, act;

    assign lim       = (state == GAP) ? 8'(CS_GAP - 1) : 8'(CLK_DIV - 1);
    assign phase_end = cnt == lim;

    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOW : IDLE;
            LOW:     state_n = phase_end ? HIGH : LOW;
            HIGH:    state_n = phase_end ? ((bidx == 4'd15) ? HOLD : LOW) : HIGH;
            HOLD:    state_n = phase_end ? GAP : HOLD;
            GAP:     state_n = phase_end ? IDLE : GAP;
            default: state_n = IDLE;
        endcase
    end

    // bidx counts bits already sent; the upper half (bidx[3]) is the data byte
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            bidx  <= '0;
            sr    <= '0;
            cap   <= '0;
            rdata <= '0;
        end else begin
            cnt <= (state == IDLE || phase_end) ? 8'd0 : cnt + 8'd1;
            if (state == IDLE && start) begin
                sr   <= {rw, addr, wdata};
                bidx <= '0;
            end
            if (state == HIGH && phase_end && bidx != 4'd15) begin
                sr   <= {sr[14:0], 1'b0};
                bidx <= bidx + 4'd1;
            end
            if (state == HIGH && cnt == 8'd0 && bidx[3])
                cap <= {cap[6:0], cipo};
            if (state == HOLD && phase_end)
                rdata <= cap;
        end
    end

    always_comb begin
        act  = state == LOW || state == HIGH || state == HOLD;
        ncs  = !act;
        sclk = state == HIGH;
        copi = act & sr[15];
        busy = state != IDLE;
        done = state == GAP && cnt == 8'd0;
    end
endmodule

// File: tb/tb_spi_ctrl_master.sv
// tb_spi_ctrl_master: scoreboard bench driving a CLK_DIV=2 and a CLK_DIV=1 instance with directed frames.
module tb_spi_ctrl_master;
    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rd;
        bit          chk_rd;
    } exp_t;

    logic       clk = 0;
    logic       rst = 1;
    logic [1:0] start = '0;
    logic       rw = 0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] cipo_pat = '0;
    logic [1:0] cipo, busy, done, ncs, sclk, copi;
    logic [7:0] rdata [2];

    exp_t q0[$], q1[$];
    int   applied = 0, miscompares = 0;
    bit   tmo = 0, fin = 0, fin_done = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gi
        int re = 0;
        spi_ctrl_master #(.CLK_DIV(g == 0 ? 2 : 1), .CS_GAP(4)) dut (
            .clk(clk), .rst(rst), .start(start[g]), .rw(rw), .addr(addr), .wdata(wdata),
            .cipo(cipo[g]), .busy(busy[g]), .done(done[g]), .rdata(rdata[g]),
            .ncs(ncs[g]), .sclk(sclk[g]), .copi(copi[g])
        );
        // peripheral model: after the n-th rising edge, present data bit (16-n) for the data byte
        always @(posedge sclk[g] or posedge ncs[g]) re = ncs[g] ? 0 : re + 1;
        assign cipo[g] = (re >= 9 && re <= 16) ? cipo_pat[3'(16 - re)] : 1'b0;
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    logic [15:0] fr [2];
    int          ed [2], nl [2], lat [2], gp [2], nh [2];
    bit          lat_on [2], ingap [2], ok [2], seen [2];
    logic        pb [2], ps [2], pc [2], pn [2];
    bit          rst_prev = 0;
    exp_t        e;
    bit          have;
    int          dv;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            dv = (k == 0) ? 2 : 1;
            if (rst_prev) begin
                chk($sformatf("reset_outs%0d", k), {ncs[k], sclk[k], copi[k], busy[k], done[k]}, 5'b10000);
                chk($sformatf("reset_rdata%0d", k), rdata[k], 0);
                ed[k] = 0; nl[k] = 0; lat_on[k] = 0; ingap[k] = 0; ok[k] = 1; seen[k] = 0; nh[k] = 0;
            end else begin
                if (busy[k] && !pb[k]) begin
                    if (seen[k]) chk($sformatf("ncs_gap%0d", k), nh[k] >= 4, 1);
                    lat[k] = 1; lat_on[k] = 1; ed[k] = 0; fr[k] = '0; nl[k] = 0; ok[k] = 1; nh[k] = 0;
                end else if (lat_on[k]) lat[k]++;
                if (ncs[k]) nh[k]++;
                else nl[k]++;
                if (sclk[k] && !ps[k]) begin
                    if (ncs[k]) ok[k] = 0;
                    ed[k]++;
                    fr[k] = {fr[k][14:0], copi[k]};
                end
                if (!ncs[k] && !pn[k] && !(ps[k] && !sclk[k] && ed[k] < 16) && copi[k] !== pc[k]) ok[k] = 0;
                if (done[k]) begin
                    have = (k == 0) ? q0.size() > 0 : q1.size() > 0;
                    if (!have) chk($sformatf("unexpected_done%0d", k), 1, 0);
                    else begin
                        if (k == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk($sformatf("frame%0d", k), fr[k], e.frame);
                        chk($sformatf("edges%0d", k), ed[k], 16);
                        chk($sformatf("ncs_low%0d", k), nl[k], 33 * dv);
                        chk($sformatf("latency%0d", k), lat[k], 33 * dv + 1);
                        chk($sformatf("copi_stable%0d", k), ok[k], 1);
                        if (e.chk_rd) chk($sformatf("rdata%0d", k), rdata[k], e.rd);
                    end
                    ingap[k] = 1; gp[k] = 0; seen[k] = 1; nh[k] = 1; lat_on[k] = 0;
                end
                if (ingap[k]) begin
                    if (busy[k]) gp[k]++;
                    else begin
                        chk($sformatf("busy_tail%0d", k), gp[k], 4);
                        ingap[k] = 0;
                    end
                end
            end
            pb[k] = busy[k]; ps[k] = sclk[k]; pc[k] = copi[k]; pn[k] = ncs[k];
        end
        rst_prev = rst;
        if (fin && !fin_done) begin
            chk("leftover_expected", q0.size() + q1.size(), 0);
            chk("timeout", tmo, 0);
            fin_done = 1;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(int k, logic [15:0] f, bit c, logic [7:0] rd);
        exp_t x;
        x.frame = f; x.chk_rd = c; x.rd = rd;
        if (k == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic wait_idle(int k);
        int t = 0;
        while (busy[k] && t < 500) begin cyc(1); t++; end
        if (busy[k]) tmo = 1;
        cyc(3);
    endtask

    task automatic issue(int k, logic r, logic [6:0] a, logic [7:0] w, logic [15:0] f, bit c, logic [7:0] rd);
        push(k, f, c, rd);
        rw = r; addr = a; wdata = w; start[k] = 1;
        cyc(1);
        start[k] = 0;
        wait_idle(k);
    endtask

    initial begin
        int t;
        cyc(3);
        rst = 0;
        cyc(2);
        issue(0, 1, 7'h00, 8'hF0, 16'h80F0, 0, 0);
        cipo_pat = 8'hA5;
        issue(0, 0, 7'h04, 8'h00, 16'h0400, 1, 8'hA5);
        // start held across two frames: second accepted on the first IDLE cycle
        push(0, 16'h8155, 0, 0);
        push(0, 16'h82AA, 0, 0);
        rw = 1; addr = 7'h01; wdata = 8'h55; start[0] = 1;
        cyc(1);
        addr = 7'h02; wdata = 8'hAA;
        t = 0;
        while (busy[0] && t < 500) begin cyc(1); t++; end
        if (busy[0]) tmo = 1;
        cyc(1);
        start[0] = 0;
        wait_idle(0);
        // start pulses while busy must not disturb or queue
        push(0, 16'h913C, 0, 0);
        rw = 1; addr = 7'h11; wdata = 8'h3C; start[0] = 1;
        cyc(1);
        start[0] = 0;
        cyc(10);
        rw = 0; addr = 7'h22; wdata = 8'hC3; start[0] = 1;
        cyc(3);
        start[0] = 0;
        cyc(20);
        start[0] = 1;
        cyc(1);
        start[0] = 0;
        wait_idle(0);
        cyc(80);
        // abort after the 7th rising edge: no done expected
        rw = 1; addr = 7'h33; wdata = 8'h5A; start[0] = 1;
        cyc(1);
        start[0] = 0;
        t = 0;
        while (gi[0].re < 7 && t < 500) begin cyc(1); t++; end
        if (gi[0].re < 7) tmo = 1;
        rst = 1;
        cyc(1);
        rst = 0;
        cyc(3);
        issue(0, 1, 7'h33, 8'h5A, 16'hB35A, 0, 0);
        issue(1, 1, 7'h7F, 8'hFF, 16'hFFFF, 0, 0);
        cipo_pat = 8'h3C;
        issue(1, 0, 7'h05, 8'h00, 16'h0500, 1, 8'h3C);
        fin = 1;
        t = 0;
        while (!fin_done && t < 10) begin cyc(1); t++; end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/spi_ctrl_master.md
Name: spi_ctrl_master

Overview:
- SPI mode-0 controller that drives the other end of the SPI register-write interface used by tt_um_uwasic_onboarding_gong.
- Serialises one 16-bit frame per request: {rw, addr[6:0], data[7:0]}, MSB first, on nCS/SCLK/COPI.
- Optionally samples CIPO during the data byte.
- Used in the top-level bench harness and in on-chip self-configuration to program the peripheral's registers.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 1..255.
- CS_GAP, 4, minimum clk cycles nCS stays high between frames; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only while busy=0.
- rw  in  1  frame bit 15; 1 = write, 0 = read.
- addr  in  7  register address, frame bits 14:8.
- wdata  in  8  write data, frame bits 7:0.
- cipo  in  1  serial data from peripheral.
- busy  out  1  high from the cycle after start is accepted until the CS_GAP period ends.
- done  out  1  one-cycle pulse at frame end.
- rdata  out  8  data-byte bits captured from cipo; stable from done until the next accepted start.
- ncs  out  1  chip select, active low.
- sclk  out  1  serial clock, idles low (CPOL=0).
- copi  out  1  serial data to peripheral.

Behaviour:
- Reset values (next edge with rst=1, from any state, including mid-frame): ncs=1, sclk=0, copi=0, busy=0, done=0, rdata=0, FSM=IDLE. An aborted frame produces no done pulse.
- FSM states: IDLE, LOW, HIGH, HOLD, GAP.
- IDLE:
  - On start=1, latch {rw, addr, wdata} into a 16-bit shift register and go to LOW.
  - Cycle after acceptance: ncs=0, busy=1, copi=frame[15].
  - start while busy=1 is ignored (not queued). Inputs are only sampled at acceptance.
- LOW:
  - sclk=0 for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - sclk=1 for CLK_DIV cycles.
  - On the first cycle sclk=1 (the rising edge), sample cipo. For bits 7..0 of the frame, shift it into the rdata capture register, MSB first.
  - After CLK_DIV cycles: if bits remain, sclk returns to 0, copi advances to the next bit, go to LOW. After bit 0, go to HOLD.
- COPI changes only on the first cycle of a LOW phase. It is constant for the full 2*CLK_DIV bit period, so data is stable at every rising edge.
- HOLD:
  - sclk=0, ncs=0, copi holds bit 0, for CLK_DIV cycles.
  - Then go to GAP: ncs=1, copi=0, done=1 for exactly that first cycle, rdata updated the same cycle.
- GAP:
  - ncs=1 for CS_GAP cycles, busy remains 1, then go to IDLE with busy=0.
  - start is accepted on the first IDLE cycle.
- Timing:
  - ncs low duration = 33*CLK_DIV cycles.
  - start-accept to done = 33*CLK_DIV+1 cycles.
  - Exactly 16 rising sclk edges per frame. No sclk edges while ncs=1.
- rw does not change sequencing; read frames shift wdata as given. Callers use wdata=0 for reads.
- cipo X/undriven on write frames: rdata is still updated; the bench checks rdata on read frames only.

Test Plan:
- Write with CLK_DIV=2, CS_GAP=4: start with rw=1, addr=0x00, wdata=0xF0 -> COPI at the 16 rising edges = 0x80F0; ncs low for 66 cycles; done exactly once, 67 cycles after acceptance; busy falls 4 cycles after done.
- Read capture: rw=0, addr=0x04, wdata=0; the peripheral model drives 0xA5 on cipo, MSB first, during bits 7..0 -> rdata=0xA5 at done; COPI frame = 0x0400.
- Back-to-back: start held high continuously for 2 frames (addr 0x01 data 0x55, then addr 0x02 data 0xAA) -> second acceptance on the first IDLE cycle; ncs high for at least 4 cycles between frames; both frames correct.
- Start while busy: extra start pulses mid-frame with different addr/wdata -> the in-flight frame is unchanged; no extra frame is emitted.
- Reset mid-frame: rst asserted after the 7th rising edge -> next cycle ncs=1, sclk=0, copi=0, busy=0; no done pulse; a new start then produces a clean, full 16-edge frame.
- CLK_DIV=1 corner: write addr 0x7F, data 0xFF -> sclk = clk/2; 16 edges; ncs low 33 cycles; COPI stable at every rising edge.
